intr_ctrl: RTL and testbench

INTR_CTRL -- requirements
Module: intr_ctrl

---
 rtl/intr_ctrl.sv | 176 +++++++++++++++++
 tb/tb_intr_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// intr_ctrl: prioritised interrupt controller (lowest index wins, no nesting).
// Ports: clk, rst (async active-low); irq_src raw lines; cfg_we/cfg_addr/
// cfg_wdata/cfg_rdata CSR access (0 ENABLE, 1 MODE, 2 PENDING, 3 STATUS);
// irq_req/irq_id request to the core; irq_ack trap taken; irq_eoi mret.
// Build option: define INTR_CTRL_SYNC_EN for a 2-flop synchronizer per source.
module intr_ctrl #(
  parameter  int NUM_SRC = 8,
  localparam int ID_W    = ($clog2(NUM_SRC) > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               cfg_we,
  input  logic [1:0]         cfg_addr,
  input  logic [NUM_SRC-1:0] cfg_wdata,
  output logic [31:0]        cfg_rdata,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack,
  input  logic               irq_eoi
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [1:0] A_ENABLE  = 2'd0;
  localparam logic [1:0] A_MODE    = 2'd1;
  localparam logic [1:0] A_PENDING = 2'd2;
  localparam logic [1:0] A_STATUS  = 2'd3;

  state_t             state;
  logic [NUM_SRC-1:0] src_in;
  logic [NUM_SRC-1:0] s_q;
  logic [NUM_SRC-1:0] s_prev;
  logic [NUM_SRC-1:0] enable;
  logic [NUM_SRC-1:0] mode;
  logic [NUM_SRC-1:0] edge_pend;
  logic [NUM_SRC-1:0] edge_pend_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] ack_clr;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] arm;
  logic [ID_W-1:0]    sel;
  logic               any_arm;
  logic               held;
  logic               wr_enable;
  logic               wr_mode;
  logic               wr_pending;
  logic               take_ack;

`ifdef INTR_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync_a;
  logic [NUM_SRC-1:0] sync_b;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= irq_src;
      sync_b <= sync_a;
    end
  end

  assign src_in = sync_b;
`else
  assign src_in = irq_src;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q    <= '0;
      s_prev <= '0;
    end else begin
      s_q    <= src_in;
      s_prev <= s_q;
    end
  end

  assign wr_enable  = cfg_we && (cfg_addr == A_ENABLE);
  assign wr_mode    = cfg_we && (cfg_addr == A_MODE);
  assign wr_pending = cfg_we && (cfg_addr == A_PENDING);
  assign take_ack   = (state == REQ) && irq_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      enable <= '0;
      mode   <= '0;
    end else begin
      if (wr_enable) enable <= cfg_wdata;
      if (wr_mode)   mode   <= cfg_wdata;
    end
  end

  // Edge capture: a new rising edge beats any clear in the same cycle,
  // whether it comes from a W1C write or from the core's acknowledge.
  assign rise    = s_q & ~s_prev;
  assign w1c     = wr_pending ? (cfg_wdata & mode) : '0;
  assign ack_clr = take_ack
                 ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id)
                 : '0;

  assign edge_pend_d =
    (rise | (edge_pend & ~(w1c | ack_clr))) & mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) edge_pend <= '0;
    else      edge_pend <= edge_pend_d;
  end

  assign pending = (edge_pend & mode) | (s_q & ~mode);

  // Level sources arm the FSM only after two equal samples, giving both
  // source kinds the same k+2 request latency; withdrawal uses the
  // visible PENDING bit so it follows the level one edge later.
  assign arm = ((edge_pend & mode) | (s_q & s_prev & ~mode)) & enable;
  assign any_arm = |arm;
  assign held    = pending[irq_id] & enable[irq_id];

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (arm[i]) sel = ID_W'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      irq_req <= 1'b0;
      irq_id  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_arm) begin
            state   <= REQ;
            irq_req <= 1'b1;
            irq_id  <= sel;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
          end else if (!held) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (irq_eoi) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      A_ENABLE:  cfg_rdata = 32'(enable);
      A_MODE:    cfg_rdata = 32'(mode);
      A_PENDING: cfg_rdata = 32'(pending);
      A_STATUS:  cfg_rdata = 32'({state, irq_id});
      default:   cfg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: directed vector table plus hand sequences for intr_ctrl.
// Ports: none (drives every intr_ctrl port, prints one summary line).
module tb_intr_ctrl;

`ifdef INTR_CTRL_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        clk;
  logic        rst;
  logic [7:0]  irq_src;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        irq_req;
  logic [2:0]  irq_id;
  logic        irq_ack;
  logic        irq_eoi;

  int n_cmp = 0;
  int n_err = 0;

  intr_ctrl #(.NUM_SRC(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_src   (irq_src),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .cfg_rdata (cfg_rdata),
    .irq_req   (irq_req),
    .irq_id    (irq_id),
    .irq_ack   (irq_ack),
    .irq_eoi   (irq_eoi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [7:0]  wd;
    logic [7:0]  src;
    logic        ack;
    logic        eoi;
    logic [1:0]  ra;
    logic        req;
    logic [2:0]  id;
    logic [31:0] rd;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t V(
    input logic we, input logic [1:0] addr, input logic [7:0] wd,
    input logic [7:0] src, input logic ack, input logic eoi,
    input logic [1:0] ra, input logic req, input logic [2:0] id,
    input logic [31:0] rd);
    vec_t v;
    v.we = we; v.addr = addr; v.wd = wd; v.src = src;
    v.ack = ack; v.eoi = eoi; v.ra = ra;
    v.req = req; v.id = id; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] a,
                        input logic [31:0] exp);
    cfg_addr = a;
    #1;
    chk(nm, cfg_rdata, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    irq_src = '0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    irq_ack = 0; irq_eoi = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_we = 0;
  endtask

  // Pulse source 0 for one cycle and count edges until irq_req.
  task automatic pulse_and_wait(input string nm, output int got);
    got = 0;
    irq_src = 8'h01;
    tick();
    irq_src = 8'h00;
    if (irq_req) got = 1;
    for (int n = 2; n <= 12 && got == 0; n++) begin
      tick();
      if (irq_req) got = n;
    end
    chk(nm, got, LAT + 1);
  endtask

  initial begin : wdog
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int got;

    rst = 1'b0;
    irq_src = '0; cfg_we = 0; cfg_addr = '0; cfg_wdata = '0;
    irq_ack = 0; irq_eoi = 0;
    repeat (3) @(negedge clk);
    chk("rst.req", irq_req, 0);
    chk("rst.id", irq_id, 0);
    rd_chk("rst.enable", 2'd0, 0);
    rd_chk("rst.mode", 2'd1, 0);
    rd_chk("rst.pending", 2'd2, 0);
    rd_chk("rst.status", 2'd3, 0);
    @(negedge clk);
    rst = 1'b1;

`ifndef INTR_CTRL_SYNC_EN
    // single edge source 0: request, ack, eoi
    vt.push_back(V(1,0,8'h01,8'h00,0,0, 0, 0,0,32'h01));
    vt.push_back(V(1,1,8'h01,8'h00,0,0, 1, 0,0,32'h01));
    vt.push_back(V(0,0,8'h00,8'h01,0,0, 2, 0,0,32'h00));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 2, 0,0,32'h01));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 3, 1,0,32'h08));
    vt.push_back(V(0,0,8'h00,8'h00,1,0, 2, 0,0,32'h00));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 3, 0,0,32'h10));
    vt.push_back(V(0,0,8'h00,8'h00,0,1, 3, 0,0,32'h00));
    vt.push_back(V(0,0,8'h00,8'h00,1,0, 3, 0,0,32'h00));
    // level 5 and 2 together, back-to-back after eoi
    vt.push_back(V(1,1,8'h00,8'h00,0,0, 1, 0,0,32'h00));
    vt.push_back(V(1,0,8'hFF,8'h00,0,0, 0, 0,0,32'hFF));
    vt.push_back(V(0,0,8'h00,8'h24,0,0, 2, 0,0,32'h24));
    vt.push_back(V(0,0,8'h00,8'h24,0,0, 3, 0,0,32'h00));
    vt.push_back(V(0,0,8'h00,8'h24,0,0, 3, 1,2,32'h0A));
    vt.push_back(V(0,0,8'h00,8'h24,1,0, 3, 0,2,32'h12));
    vt.push_back(V(0,0,8'h00,8'h24,0,1, 3, 0,2,32'h02));
    vt.push_back(V(0,0,8'h00,8'h24,0,0, 3, 1,2,32'h0A));
    vt.push_back(V(0,0,8'h00,8'h00,1,0, 3, 0,2,32'h12));
    vt.push_back(V(0,0,8'h00,8'h00,0,1, 3, 0,2,32'h02));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 3, 0,2,32'h02));
    // level 3 withdrawn; eoi ignored in REQ; no priority replace
    vt.push_back(V(0,0,8'h00,8'h08,0,0, 2, 0,2,32'h08));
    vt.push_back(V(0,0,8'h00,8'h08,0,0, 3, 0,2,32'h02));
    vt.push_back(V(0,0,8'h00,8'h08,0,0, 3, 1,3,32'h0B));
    vt.push_back(V(0,0,8'h00,8'h09,0,1, 3, 1,3,32'h0B));
    vt.push_back(V(0,0,8'h00,8'h09,0,0, 3, 1,3,32'h0B));
    vt.push_back(V(0,0,8'h00,8'h01,0,0, 2, 1,3,32'h01));
    vt.push_back(V(0,0,8'h00,8'h01,0,0, 3, 0,3,32'h03));
    vt.push_back(V(0,0,8'h00,8'h01,0,0, 3, 1,0,32'h08));
    vt.push_back(V(0,0,8'h00,8'h00,1,0, 3, 0,0,32'h10));
    vt.push_back(V(0,0,8'h00,8'h00,0,1, 3, 0,0,32'h00));
    // serving level 1, edge on 0 waits for eoi
    vt.push_back(V(1,1,8'h01,8'h02,0,0, 2, 0,0,32'h02));
    vt.push_back(V(0,0,8'h00,8'h02,0,0, 3, 0,0,32'h00));
    vt.push_back(V(0,0,8'h00,8'h02,0,0, 3, 1,1,32'h09));
    vt.push_back(V(0,0,8'h00,8'h02,1,0, 3, 0,1,32'h11));
    vt.push_back(V(0,0,8'h00,8'h01,0,0, 2, 0,1,32'h00));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 2, 0,1,32'h01));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 3, 0,1,32'h11));
    vt.push_back(V(0,0,8'h00,8'h00,0,1, 3, 0,1,32'h01));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 3, 1,0,32'h08));
    vt.push_back(V(0,0,8'h00,8'h00,1,0, 2, 0,0,32'h00));
    vt.push_back(V(0,0,8'h00,8'h00,0,1, 3, 0,0,32'h00));
    // W1C vs new edge on 4; level W1C ignored; STATUS read-only
    vt.push_back(V(1,0,8'h00,8'h00,0,0, 0, 0,0,32'h00));
    vt.push_back(V(1,1,8'h10,8'h10,0,0, 1, 0,0,32'h10));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 2, 0,0,32'h10));
    vt.push_back(V(0,0,8'h00,8'h10,0,0, 2, 0,0,32'h10));
    vt.push_back(V(1,2,8'h10,8'h10,0,0, 2, 0,0,32'h10));
    vt.push_back(V(1,2,8'h10,8'h10,0,0, 2, 0,0,32'h00));
    vt.push_back(V(1,1,8'h00,8'h10,0,0, 2, 0,0,32'h10));
    vt.push_back(V(1,2,8'h10,8'h10,0,0, 2, 0,0,32'h10));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 2, 0,0,32'h00));
    vt.push_back(V(1,3,8'hFF,8'h00,0,0, 3, 0,0,32'h00));
    // disable withdraws a held request
    vt.push_back(V(1,0,8'hFF,8'h40,0,0, 2, 0,0,32'h40));
    vt.push_back(V(0,0,8'h00,8'h40,0,0, 3, 0,0,32'h00));
    vt.push_back(V(0,0,8'h00,8'h40,0,0, 3, 1,6,32'h0E));
    vt.push_back(V(1,0,8'hBF,8'h40,0,0, 0, 1,6,32'hBF));
    vt.push_back(V(0,0,8'h00,8'h40,0,0, 3, 0,6,32'h06));
    vt.push_back(V(0,0,8'h00,8'h00,0,0, 3, 0,6,32'h06));

    foreach (vt[i]) begin
      cfg_we = vt[i].we; cfg_addr = vt[i].addr; cfg_wdata = vt[i].wd;
      irq_src = vt[i].src; irq_ack = vt[i].ack; irq_eoi = vt[i].eoi;
      tick();
      cfg_we = 0; irq_ack = 0; irq_eoi = 0;
      cfg_addr = vt[i].ra;
      #1;
      chk($sformatf("v%0d.req", i), irq_req, vt[i].req);
      chk($sformatf("v%0d.id", i), irq_id, vt[i].id);
      chk($sformatf("v%0d.rd", i), cfg_rdata, vt[i].rd);
    end
`endif

    // latency of a one-cycle edge pulse, then ack and eoi
    do_reset();
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h01);
    pulse_and_wait("lat.edge", got);
    chk("lat.id", irq_id, 0);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    chk("lat.ack_req", irq_req, 0);
    rd_chk("lat.pending", 2'd2, 0);
    rd_chk("lat.status_svc", 2'd3, 32'h10);
    irq_eoi = 1;
    tick();
    irq_eoi = 0;
    rd_chk("lat.status_idle", 2'd3, 0);

    // asynchronous reset in the middle of a request
    pulse_and_wait("lat.again", got);
    #2;
    rst = 1'b0;
    #1;
    chk("arst.req", irq_req, 0);
    rd_chk("arst.enable", 2'd0, 0);
    rd_chk("arst.mode", 2'd1, 0);
    rd_chk("arst.pending", 2'd2, 0);
    rd_chk("arst.status", 2'd3, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (LAT + 2) tick();
    chk("arst.no_residual", irq_req, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
